// File: rtl/tt_bus_pkg.sv
// Shared types and elaboration-time helpers for the tt_bus sequencer.
// The phase codes are the pin_phase encoding.
package tt_bus_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_ADDR = 2'b01,
    PH_DATA = 2'b10,
    PH_DONE = 2'b11
  } phase_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tt_bus_beat_mux.sv
// Selects one PW-wide address beat from the latched address.
// The final beat is zero-padded when AW is not a multiple of PW.
module tt_bus_beat_mux
  import tt_bus_pkg::*;
#(
  parameter  int AW      = 16,
  parameter  int PW      = 8,
  localparam int N_BEATS = ceil_div(AW, PW),
  localparam int BW      = min1_clog2(N_BEATS)
) (
  input  logic [AW-1:0] addr,
  input  logic [BW-1:0] beat,
  output logic [PW-1:0] slice
);

  localparam int PADW = N_BEATS * PW;

  logic [PADW-1:0] addr_pad;

  assign addr_pad = PADW'(addr);

  always_comb begin
    slice = '0;
    for (int i = 0; i < N_BEATS; i++) begin
      if (beat == BW'(i)) slice = addr_pad[i*PW +: PW];
    end
  end

endmodule

// File: rtl/tt_bus_sequencer.sv
// Sequences one CPU bus cycle onto a narrow pin port: address beats, a data
// phase with wait states and external ready, then a one-cycle completion.
module tt_bus_sequencer
  import tt_bus_pkg::*;
#(
  parameter  int AW          = 16,
  parameter  int DW          = 8,
  parameter  int PW          = 8,
  parameter  int WAIT_CYCLES = 0,
  localparam int N_BEATS     = ceil_div(AW, PW),
  localparam int BW          = min1_clog2(N_BEATS),
  localparam int WW          = min1_clog2(WAIT_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  input  logic          cpu_req,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_rdy,
  input  logic          ext_rdy,
  output logic [PW-1:0] pin_out,
  output logic [1:0]    pin_phase,
  output logic [BW-1:0] pin_beat,
  output logic          pin_strobe,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic [DW-1:0] bus_oe
);

  phase_e        state_q,  state_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic [DW-1:0] data_q,   data_d;
  logic          we_q,     we_d;
  logic [BW-1:0] beat_q,   beat_d;
  logic [WW-1:0] wait_q,   wait_d;
  logic [DW-1:0] di_q,     di_d;
  logic          rdy_q,    rdy_d;
  logic [PW-1:0] pout_q,   pout_d;
  logic [BW-1:0] pbeat_q,  pbeat_d;
  logic          strobe_q, strobe_d;
  logic [DW-1:0] oe_q,     oe_d;
  logic [PW-1:0] beat_slice;

  // Fed from the next-state address/beat so the slice lands in pout_q on
  // the same edge the state enters or advances through ADDR.
  tt_bus_beat_mux #(
    .AW(AW),
    .PW(PW)
  ) u_beat_mux (
    .addr  (addr_d),
    .beat  (beat_d),
    .slice (beat_slice)
  );

  // NOTE: every signal gets its default before the case so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    di_d    = di_q;
    unique case (state_q)
      PH_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_ab;
          data_d  = cpu_do;
          we_d    = cpu_we;
          beat_d  = '0;
          state_d = PH_ADDR;
        end
      end
      PH_ADDR: begin
        if (beat_q == BW'(N_BEATS - 1)) begin
          wait_d  = WW'(WAIT_CYCLES);
          state_d = PH_DATA;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      PH_DATA: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end else if (ext_rdy) begin
          if (!we_q) di_d = bus_in;
          state_d = PH_DONE;
        end
      end
      PH_DONE: state_d = PH_IDLE;
      default: state_d = PH_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so nothing on
  // the pins depends combinationally on cpu_* or bus_in.
  always_comb begin
    pout_d   = '0;
    pbeat_d  = '0;
    strobe_d = 1'b0;
    oe_d     = '0;
    rdy_d    = 1'b0;
    unique case (state_d)
      PH_ADDR: begin
        pout_d   = beat_slice;
        pbeat_d  = beat_d;
        strobe_d = 1'b1;
      end
      PH_DATA: begin
        pout_d = PW'(we_d);
        oe_d   = {DW{we_d}};
      end
      PH_DONE: rdy_d = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= PH_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
      di_q     <= '0;
      rdy_q    <= 1'b0;
      pout_q   <= '0;
      pbeat_q  <= '0;
      strobe_q <= 1'b0;
      oe_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      di_q     <= di_d;
      rdy_q    <= rdy_d;
      pout_q   <= pout_d;
      pbeat_q  <= pbeat_d;
      strobe_q <= strobe_d;
      oe_q     <= oe_d;
    end
  end

  assign pin_phase  = state_q;
  assign pin_out    = pout_q;
  assign pin_beat   = pbeat_q;
  assign pin_strobe = strobe_q;
  assign cpu_rdy    = rdy_q;
  assign cpu_di     = di_q;
  assign bus_out    = data_q;
  assign bus_oe     = oe_q;

endmodule

// File: tb/tb_tt_bus_sequencer.sv
// Self-checking bench: three sequencer configurations (default, two wait
// states, 20-bit address) driven one at a time against a phase-level model.
module tb_tt_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_req;
  logic        ext_rdy;
  logic [7:0]  bus_in;
  int          sel;
  logic [2:0]  req_v;

  always #5 clk = ~clk;

  assign req_v[0] = cpu_req && (sel == 0);
  assign req_v[1] = cpu_req && (sel == 1);
  assign req_v[2] = cpu_req && (sel == 2);

  logic [7:0] di0, di1, di2, pout0, pout1, pout2, bout0, bout1, bout2, oe0, oe1, oe2;
  logic [1:0] ph0, ph1, ph2;
  logic       rdy0, rdy1, rdy2, strb0, strb1, strb2;
  logic [0:0] beat0, beat1;
  logic [1:0] beat2;

  tt_bus_sequencer u_def (
    .clk(clk), .rst_n(rst_n), .cpu_ab(cpu_ab[15:0]), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_req(req_v[0]), .cpu_di(di0), .cpu_rdy(rdy0), .ext_rdy(ext_rdy), .pin_out(pout0),
    .pin_phase(ph0), .pin_beat(beat0), .pin_strobe(strb0), .bus_in(bus_in),
    .bus_out(bout0), .bus_oe(oe0)
  );

  tt_bus_sequencer #(.WAIT_CYCLES(2)) u_wait (
    .clk(clk), .rst_n(rst_n), .cpu_ab(cpu_ab[15:0]), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_req(req_v[1]), .cpu_di(di1), .cpu_rdy(rdy1), .ext_rdy(ext_rdy), .pin_out(pout1),
    .pin_phase(ph1), .pin_beat(beat1), .pin_strobe(strb1), .bus_in(bus_in),
    .bus_out(bout1), .bus_oe(oe1)
  );

  tt_bus_sequencer #(.AW(20)) u_odd (
    .clk(clk), .rst_n(rst_n), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_req(req_v[2]), .cpu_di(di2), .cpu_rdy(rdy2), .ext_rdy(ext_rdy), .pin_out(pout2),
    .pin_phase(ph2), .pin_beat(beat2), .pin_strobe(strb2), .bus_in(bus_in),
    .bus_out(bout2), .bus_oe(oe2)
  );

  logic [7:0] o_di, o_pout, o_bout, o_oe;
  logic [1:0] o_ph, o_beat;
  logic       o_rdy, o_strb;

  always_comb begin
    o_di = '0; o_pout = '0; o_bout = '0; o_oe = '0; o_ph = '0; o_beat = '0;
    o_rdy = 1'b0; o_strb = 1'b0;
    case (sel)
      0: begin
        o_di = di0; o_pout = pout0; o_bout = bout0; o_oe = oe0; o_ph = ph0;
        o_beat = {1'b0, beat0}; o_rdy = rdy0; o_strb = strb0;
      end
      1: begin
        o_di = di1; o_pout = pout1; o_bout = bout1; o_oe = oe1; o_ph = ph1;
        o_beat = {1'b0, beat1}; o_rdy = rdy1; o_strb = strb1;
      end
      default: begin
        o_di = di2; o_pout = pout2; o_bout = bout2; o_oe = oe2; o_ph = ph2;
        o_beat = beat2; o_rdy = rdy2; o_strb = strb2;
      end
    endcase
  end

  // Model: per-configuration beat count and wait states, plus last captured
  // read data and last latched write data.
  int         nb[3] = '{2, 2, 3};
  int         wc[3] = '{0, 2, 0};
  logic [7:0] exp_di[3];
  logic [7:0] exp_do[3];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [1:0] ph, input logic [7:0] pout,
                             input logic [1:0] bt, input logic strb, input logic [7:0] oe,
                             input logic rdy);
    check({tag, ".phase"},  32'(o_ph),   32'(ph));
    if (ph != 2'b11) check({tag, ".pin_out"}, 32'(o_pout), 32'(pout));
    if (ph == 2'b01) check({tag, ".pin_beat"}, 32'(o_beat), 32'(bt));
    check({tag, ".strobe"}, 32'(o_strb), 32'(strb));
    check({tag, ".bus_oe"}, 32'(o_oe),   32'(oe));
    check({tag, ".cpu_rdy"}, 32'(o_rdy), 32'(rdy));
    check({tag, ".cpu_di"}, 32'(o_di),   32'(exp_di[sel]));
    check({tag, ".bus_out"}, 32'(o_bout), 32'(exp_do[sel]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cpu_ab  = 20'($urandom);
    cpu_do  = 8'($urandom);
    cpu_we  = 1'($urandom);
    cpu_req = 1'($urandom);
    bus_in  = 8'($urandom);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 3; i++) begin
      exp_di[i] = '0;
      exp_do[i] = '0;
    end
  endtask

  // One full bus cycle on configuration s. stall = ext_rdy-low cycles after
  // the mandatory waits; abort = reset during the first data cycle.
  task automatic do_txn(input int s, input logic [19:0] addr, input logic [7:0] data,
                        input logic we, input logic [7:0] bin, input int stall, input bit abort);
    int n_data;
    sel     = s;
    cpu_ab  = addr;
    cpu_do  = data;
    cpu_we  = we;
    cpu_req = 1'b1;
    ext_rdy = 1'($urandom);
    bus_in  = 8'($urandom);
    step();
    exp_do[s] = data;
    for (int i = 0; i < nb[s]; i++) begin
      check_cycle("addr", 2'b01, 8'(addr >> (i * 8)), 2'(i), 1'b1, 8'h00, 1'b0);
      scramble();
      ext_rdy = 1'($urandom);
      step();
    end
    n_data = wc[s] + stall + 1;
    for (int i = 0; i < n_data; i++) begin
      check_cycle("data", 2'b10, {7'b0, we}, 2'b00, 1'b0, we ? 8'hFF : 8'h00, 1'b0);
      scramble();
      if (abort) begin
        rst_n = 1'b0;
        step();
        rst_n   = 1'b1;
        cpu_req = 1'b0;
        reset_model();
        check_cycle("rst_mid", 2'b00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
        return;
      end
      if (i < wc[s])            ext_rdy = 1'($urandom);
      else if (i == n_data - 1) ext_rdy = 1'b1;
      else                      ext_rdy = 1'b0;
      if (i == n_data - 1) bus_in = bin;
      step();
    end
    if (!we) exp_di[s] = bin;
    check_cycle("done", 2'b11, 8'h00, 2'b00, 1'b0, 8'h00, 1'b1);
    scramble();
    step();
    cpu_req = 1'b0;
    check_cycle("idle", 2'b00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    sel     = 0;
    rst_n   = 1'b0;
    cpu_req = 1'b1;
    cpu_ab  = 20'hFFFFF;
    cpu_do  = 8'hFF;
    cpu_we  = 1'b1;
    ext_rdy = 1'b1;
    bus_in  = 8'hFF;
    reset_model();
    step();
    step();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_cycle("reset", 2'b00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0);
      check("reset.pin_beat", 32'(o_beat), 32'd0);
    end
    cpu_req = 1'b0;
    rst_n   = 1'b1;
    step();

    do_txn(0, 20'h0BEEF, 8'h00, 1'b0, 8'h5A, 0, 1'b0);
    do_txn(1, 20'h01234, 8'hA5, 1'b1, 8'h00, 0, 1'b0);
    do_txn(1, 20'h0C3A7, 8'h11, 1'b0, 8'h96, 5, 1'b0);
    do_txn(0, 20'h07E01, 8'h22, 1'b1, 8'h00, 5, 1'b0);
    do_txn(2, 20'hABCDE, 8'h33, 1'b0, 8'hC4, 0, 1'b0);
    do_txn(1, 20'h0F00D, 8'hFF, 1'b1, 8'h00, 0, 1'b1);
    do_txn(1, 20'h04321, 8'h5C, 1'b1, 8'h00, 1, 1'b0);

    for (int k = 0; k < 30; k++) begin
      int          s;
      logic [19:0] a;
      s = int'($urandom_range(0, 2));
      a = 20'($urandom);
      if (s != 2) a[19:16] = 4'h0;
      do_txn(s, a, 8'($urandom), 1'($urandom), 8'($urandom),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
